// File: rtl/code_loader_pkg.sv
// rtl/code_loader_pkg.sv - shared types and constants for the boot-time code loader
// Contents:
//   state_t           : frame decoder states
//   SYNC_BYTE_DEFAULT : default frame start marker
//   COUNT_W           : width of the little-endian word-count field
//   CSUM_W            : width of the XOR checksum
package code_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         COUNT_W           = 16;
  localparam int         CSUM_W            = 8;

endpackage

// File: rtl/code_byte_packer.sv
// rtl/code_byte_packer.sv - packs data bytes little-endian into 32-bit words and XOR-accumulates them
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : synchronous restart at the start of a new frame
//   byte_valid  : byte_in is a frame data byte to absorb this cycle
//   byte_in     : data byte
//   word_valid  : this byte completes a word (combinational, same cycle as byte_valid)
//   word_out    : completed word, first byte of the word in [7:0]
//   csum        : XOR of every data byte absorbed since the last clear
module code_byte_packer
  import code_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [31:0]       word_out,
  output logic [CSUM_W-1:0] csum
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  // Bytes shift in from the top, so after three bytes the first one has
  // reached [7:0]; the fourth byte is appended directly without a register
  // stage so the word is available on the same edge it completes.
  assign word_valid = byte_valid && (lane == 2'd3);
  assign word_out   = {byte_in, shreg};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane  <= 2'd0;
      shreg <= 24'd0;
      csum  <= '0;
    end else if (byte_valid) begin
      // 2-bit lane counter wraps to 0 on the fourth byte of each word
      lane  <= lane + 2'd1;
      shreg <= {byte_in, shreg[23:8]};
      csum  <= csum ^ byte_in;
    end
  end

endmodule

// File: rtl/code_loader.sv
// rtl/code_loader.sv - decodes a framed boot image from a byte stream and writes it into code memory
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_data/in_valid      : stream byte and its qualifier
//   in_ready              : byte accepted when in_valid && in_ready at posedge
//   wr_en/wr_addr/wr_data : code-memory write port, wr_en is a one-cycle pulse
//   cpu_hold              : keeps the CPU in reset until a verified image is loaded
//   done                  : last frame loaded and checksum-valid
//   error                 : last frame rejected, held until the next sync byte
//   words_loaded          : words written in the current or last frame
module code_loader
  import code_loader_pkg::*;
#(
  parameter int         CODE_WORDS = 512,
  parameter int         ADDR_W     = $clog2(CODE_WORDS),
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(CODE_WORDS);

  state_t              state;
  state_t              next_state;

  logic                accept;
  logic                is_sync;
  logic                data_acc;
  logic                cnt_lo_ld;
  logic                cnt_hi_ld;
  logic                sync_acc;
  logic                cnt_err;
  logic                csum_ok;
  logic                csum_bad;

  logic                word_valid;
  logic [31:0]         word_out;
  logic [CSUM_W-1:0]   csum;

  logic [COUNT_W-1:0]  count_q;
  logic [COUNT_W-1:0]  count_full;
  logic [ADDR_W:0]     wl_next;
  logic [COUNT_W-1:0]  wl_next_ext;

  assign accept    = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign data_acc  = accept && (state == ST_DATA);
  assign cnt_lo_ld = accept && (state == ST_CNT_LO);
  assign cnt_hi_ld = accept && (state == ST_CNT_HI);

  // Full count as it will be once the high byte now on the bus is latched;
  // the range check has to happen on that same edge.
  assign count_full  = {in_data, count_q[7:0]};
  assign wl_next     = words_loaded + 1'b1;
  assign wl_next_ext = {{(COUNT_W-ADDR_W-1){1'b0}}, wl_next};

  code_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (sync_acc),
    .byte_valid (data_acc),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word_out   (word_out),
    .csum       (csum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    sync_acc   = 1'b0;
    cnt_err    = 1'b0;
    csum_ok    = 1'b0;
    csum_bad   = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A sync byte from DONE is a reload: same effects as from IDLE
          if (is_sync) begin
            sync_acc   = 1'b1;
            next_state = ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          next_state = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          if ((count_full == '0) || (count_full > MAX_COUNT)) begin
            cnt_err    = 1'b1;
            next_state = ST_IDLE;
          end else begin
            next_state = ST_DATA;
          end
        end
        ST_DATA: begin
          if (word_valid && (wl_next_ext == count_q)) begin
            next_state = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (in_data == csum) begin
            csum_ok    = 1'b1;
            next_state = ST_DONE;
          end else begin
            csum_bad   = 1'b1;
            next_state = ST_IDLE;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      count_q      <= '0;
    end else begin
      // No backpressure source exists yet; ready only drops during reset
      in_ready <= 1'b1;
      wr_en    <= data_acc && word_valid;
      if (data_acc && word_valid) begin
        wr_data <= word_out;
      end
      if (cnt_lo_ld) begin
        count_q[7:0] <= in_data;
      end
      if (cnt_hi_ld) begin
        count_q[15:8] <= in_data;
      end
      if (sync_acc) begin
        wr_addr      <= '0;
        words_loaded <= '0;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
      end else begin
        // Address advances on the edge after the write it belonged to,
        // so it is stable for the whole wr_en pulse.
        if (wr_en) begin
          wr_addr <= wr_addr + 1'b1;
        end
        if (data_acc && word_valid) begin
          words_loaded <= wl_next;
        end
        // Rejected frames keep the CPU held; already written words stay.
        if (cnt_err || csum_bad) begin
          error <= 1'b1;
        end
        if (csum_ok) begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// tb/tb_code_loader.sv - directed vector bench for code_loader
module tb_code_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [9:0]  words_loaded;

  code_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held across one posedge, and the outputs required just
  // after that edge. gap inserts an idle cycle (in_valid=0) before the row.
  typedef struct {
    logic        gap;
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic        hold;
    logic        dn;
    logic        er;
    logic [9:0]  wl;
  } vec_t;

  vec_t tbl[$];
  vec_t prev_exp;
  int   vectors;
  int   miscompares;

  task automatic add(input int g, input int r, input int v, input int d,
                     input int we, input int wa, input int wd,
                     input int hold, input int dn, input int er, input int wl);
    vec_t t;
    t.gap  = 1'(g);
    t.rst  = 1'(r);
    t.v    = 1'(v);
    t.d    = 8'(d);
    t.we   = 1'(we);
    t.wa   = 9'(wa);
    t.wd   = 32'(wd);
    t.hold = 1'(hold);
    t.dn   = 1'(dn);
    t.er   = 1'(er);
    t.wl   = 10'(wl);
    tbl.push_back(t);
  endtask

  // A5 02 00 | 11 22 33 44 | 55 66 77 88 | csum ; 0x88 is the correct checksum
  task automatic add_frame2(input int g, input int csum, input int good);
    add(g, 0, 1, 'hA5, 0, 0, 0, 1, 0, 0, 0);
    add(g, 0, 1, 'h02, 0, 0, 0, 1, 0, 0, 0);
    add(g, 0, 1, 'h00, 0, 0, 0, 1, 0, 0, 0);
    add(g, 0, 1, 'h11, 0, 0, 0, 1, 0, 0, 0);
    add(g, 0, 1, 'h22, 0, 0, 0, 1, 0, 0, 0);
    add(g, 0, 1, 'h33, 0, 0, 0, 1, 0, 0, 0);
    add(g, 0, 1, 'h44, 1, 0, 32'h44332211, 1, 0, 0, 1);
    add(g, 0, 1, 'h55, 0, 1, 0, 1, 0, 0, 1);
    add(g, 0, 1, 'h66, 0, 1, 0, 1, 0, 0, 1);
    add(g, 0, 1, 'h77, 0, 1, 0, 1, 0, 0, 1);
    add(g, 0, 1, 'h88, 1, 1, 32'h88776655, 1, 0, 0, 2);
    add(g, 0, 1, csum, 0, 2, 0, good ? 0 : 1, good, good ? 0 : 1, 2);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    reset    = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t t, input int idx);
    if (t.gap) begin
      // in_data carries the sync value during the gap; it must be ignored
      drive(1'b0, 1'b0, 8'hA5);
      vectors++;
      chk("gap_wr_en",    idx, 32'(wr_en), 32'd0);
      chk("gap_wr_addr",  idx, 32'(wr_addr), 32'(prev_exp.wa) + 32'(prev_exp.we));
      chk("gap_cpu_hold", idx, 32'(cpu_hold), 32'(prev_exp.hold));
      chk("gap_done",     idx, 32'(done), 32'(prev_exp.dn));
      chk("gap_error",    idx, 32'(error), 32'(prev_exp.er));
      chk("gap_words",    idx, 32'(words_loaded), 32'(prev_exp.wl));
    end
    drive(t.rst, t.v, t.d);
    vectors++;
    chk("in_ready", idx, 32'(in_ready), 32'(!t.rst));
    chk("wr_en",    idx, 32'(wr_en), 32'(t.we));
    chk("wr_addr",  idx, 32'(wr_addr), 32'(t.wa));
    if (t.we || t.rst) chk("wr_data", idx, wr_data, t.wd);
    chk("cpu_hold", idx, 32'(cpu_hold), 32'(t.hold));
    chk("done",     idx, 32'(done), 32'(t.dn));
    chk("error",    idx, 32'(error), 32'(t.er));
    chk("words_loaded", idx, 32'(words_loaded), 32'(t.wl));
    prev_exp = t;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;

    // Reset values, then in_ready rises one cycle after release
    add(0, 1, 0, 'h00, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 'hA5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 'h00, 0, 0, 0, 1, 0, 0, 0);

    // Valid two-word frame, then junk in DONE is discarded
    add_frame2(0, 'h88, 1);
    add(0, 0, 1, 'h00, 0, 2, 0, 0, 1, 0, 2);
    add(0, 0, 1, 'hFF, 0, 2, 0, 0, 1, 0, 2);

    // Reload from DONE with a bad checksum; following bytes are idle junk
    add_frame2(0, 'h00, 0);
    add(0, 0, 1, 'h11, 0, 2, 0, 1, 0, 1, 2);
    add(0, 0, 1, 'h22, 0, 2, 0, 1, 0, 1, 2);
    add(0, 0, 1, 'h33, 0, 2, 0, 1, 0, 1, 2);
    add(0, 0, 1, 'h44, 0, 2, 0, 1, 0, 1, 2);

    // A valid frame clears the sticky error
    add_frame2(0, 'h88, 1);

    // N=0 and N=513 are rejected with no writes
    add(0, 0, 1, 'hA5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h00, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h00, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'h11, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'hA5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h01, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h02, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'h11, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'h22, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'h33, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'h44, 0, 0, 0, 1, 0, 1, 0);

    // Reset after the 2nd data byte, first post-reset byte not accepted,
    // then a minimum N=1 frame loads to address 0
    add(0, 0, 1, 'hA5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h01, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h00, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h11, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h22, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 1, 'h33, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'hA5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'hA5, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h01, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h00, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'hDE, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'hAD, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'hBE, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'hEF, 1, 0, 32'hEFBEADDE, 1, 0, 0, 1);
    add(0, 0, 1, 'h22, 0, 1, 0, 0, 1, 0, 1);

    // Leading junk and an idle cycle before every byte
    add(1, 0, 1, 'h00, 0, 1, 0, 0, 1, 0, 1);
    add(1, 0, 1, 'hFF, 0, 1, 0, 0, 1, 0, 1);
    add_frame2(1, 'h88, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      apply_row(tbl[k], k);
    end

    // Largest legal frame, N=512: every word lands at its own address
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hA5);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h02);
    vectors++;
    chk("n512_count_error", -1, 32'(error), 32'd0);
    cs = 8'h00;
    for (int i = 0; i < 512; i++) begin
      w  = (32'(i) * 32'h0103_0507) ^ 32'hA5C3_5A96;
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      drive(1'b0, 1'b1, w[7:0]);
      drive(1'b0, 1'b1, w[15:8]);
      drive(1'b0, 1'b1, w[23:16]);
      drive(1'b0, 1'b1, w[31:24]);
      vectors++;
      chk("n512_wr_en",   i, 32'(wr_en), 32'd1);
      chk("n512_wr_addr", i, 32'(wr_addr), 32'(i) & 32'h1FF);
      chk("n512_wr_data", i, wr_data, w);
      chk("n512_hold",    i, 32'(cpu_hold), 32'd1);
    end
    drive(1'b0, 1'b1, cs);
    vectors++;
    chk("n512_done",  -1, 32'(done), 32'd1);
    chk("n512_hold",  -1, 32'(cpu_hold), 32'd0);
    chk("n512_error", -1, 32'(error), 32'd0);
    chk("n512_words", -1, 32'(words_loaded), 32'd512);
    chk("n512_wr_en", -1, 32'(wr_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
